// File: rtl/mcs4_mem_arbiter_pkg.sv
// Shared MCS-4 types for the program-memory arbiter: bus phase encoding,
// arbiter FSM states and requester identities.
package mcs4_mem_arbiter_pkg;

  localparam int Addr_width = 12;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef enum logic [1:0] {LOAD, RUN, HALT} arb_state_t;

  typedef enum logic {HOST, LOADER} arb_req_t;

endpackage

// File: rtl/mcs4_phase_tracker.sv
// Tracks the i4004 instruction-cycle phase (A1..X3) from cpu_sync and flags
// whether the phase count is trustworthy.
module mcs4_phase_tracker
  import mcs4_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_sync,
  input  logic       cpu_rst,
  output logic [2:0] phase,
  output logic       phase_valid
);

  instr_cyc_t phase_q, phase_d;
  logic       phase_valid_q, phase_valid_d;

  always_comb begin
    phase_d       = instr_cyc_t'(phase_q + 3'd1);
    phase_valid_d = phase_valid_q;
    if (cpu_sync) begin
      phase_d       = A1;
      phase_valid_d = 1'b1;
    end
    // A CPU held in reset produces no meaningful sync, so lock is dropped.
    if (cpu_rst) begin
      phase_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= A1;
      phase_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_valid_sel();

  function automatic logic phase_valid_valid_sel();
    return phase_valid_q;
  endfunction

endmodule

// File: rtl/mcs4_mem_arbiter.sv
// Program-memory arbiter for the i4004: CPU fetch in the A3 slot, boot loader
// and host port share the remaining cycles. Optional MCS4_ARB_WPROT_EN blocks
// host writes while the CPU runs.
module mcs4_mem_arbiter
  import mcs4_mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = Addr_width,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cpu_dbus_out,
  input  logic              cpu_sync,
  output logic [3:0]        cpu_dbus_in,
  output logic              cpu_rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_run,
  input  logic              host_reload,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  logic [2:0]        phase;
  logic              phase_valid;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  arb_req_t          rr_last_q, rr_last_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [3:0]        a1_q, a1_d, a2_q, a2_d, lo_q, lo_d;
  logic              fetch_m1_q, fetch_m1_d, fetch_m2_q, fetch_m2_d;
  logic              host_ack_q, host_ack_d, host_rd_q, host_rd_d;
  logic [7:0]        host_rdata_q;

  logic              fetch_slot, host_elig, ld_elig, grant_host, grant_ld, wr_ok;

  mcs4_phase_tracker u_phase (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_sync    (cpu_sync),
    .cpu_rst     (cpu_rst_q),
    .phase       (phase),
    .phase_valid (phase_valid)
  );

  always_comb begin
`ifdef MCS4_ARB_WPROT_EN
    wr_ok = (state_q != RUN);
`else
    wr_ok = 1'b1;
`endif

    fetch_slot = (state_q == RUN) && phase_valid && (phase == A3);
    // Requests are masked while rst_n is low so every output sits at its reset value.
    host_elig  = rst_n && host_req && !host_ack_q;
    ld_elig    = rst_n && (state_q == LOAD) && ld_valid;

    grant_host = 1'b0;
    grant_ld   = 1'b0;
    if (!fetch_slot) begin
      if (host_elig && ld_elig) begin
        if (rr_last_q == HOST) grant_ld = 1'b1;
        else                   grant_host = 1'b1;
      end else if (host_elig) begin
        grant_host = 1'b1;
      end else if (ld_elig) begin
        grant_ld = 1'b1;
      end
    end

    mem_en    = fetch_slot || grant_host || grant_ld;
    mem_we    = grant_ld || (grant_host && host_we && wr_ok);
    mem_addr  = '0;
    mem_wdata = 8'h00;
    if (fetch_slot) begin
      mem_addr = ADDR_W'({cpu_dbus_out, a2_q, a1_q});
    end else if (grant_ld) begin
      mem_addr  = load_ptr_q;
      mem_wdata = ld_data;
    end else if (grant_host) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
    ld_ready = grant_ld;

    rr_last_d = rr_last_q;
    if (grant_host)    rr_last_d = HOST;
    else if (grant_ld) rr_last_d = LOADER;

    load_ptr_d = grant_ld ? load_ptr_q + 1'b1 : load_ptr_q;
    state_d    = state_q;
    case (state_q)
      LOAD:    if (grant_ld && ld_last) state_d = host_run ? RUN : HALT;
      RUN:     if (!host_run) state_d = HALT;
      HALT:    if (host_run) state_d = RUN;
      default: state_d = LOAD;
    endcase
    // A reload wins over everything, including a last byte accepted this cycle.
    if (host_reload) begin
      state_d    = LOAD;
      load_ptr_d = LOAD_BASE;
    end
    cpu_rst_d = (state_q != RUN);

    a1_d       = (phase_valid && phase == A1) ? cpu_dbus_out : a1_q;
    a2_d       = (phase_valid && phase == A2) ? cpu_dbus_out : a2_q;
    fetch_m1_d = fetch_slot;
    fetch_m2_d = fetch_m1_q;
    lo_d       = fetch_m1_q ? mem_rdata[3:0] : lo_q;

    // Fetch drive follows the issued read, not the state, so it finishes after leaving RUN.
    cpu_dbus_in = 4'h0;
    if (fetch_m1_q)      cpu_dbus_in = mem_rdata[7:4];
    else if (fetch_m2_q) cpu_dbus_in = lo_q;

    host_ack_d = grant_host;
    host_rd_d  = grant_host && !host_we;
    host_ack   = host_ack_q;
    host_rdata = (host_ack_q && host_rd_q) ? mem_rdata : host_rdata_q;
    cpu_rst    = cpu_rst_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      load_ptr_q   <= LOAD_BASE;
      rr_last_q    <= HOST;
      cpu_rst_q    <= 1'b1;
      a1_q         <= 4'h0;
      a2_q         <= 4'h0;
      lo_q         <= 4'h0;
      fetch_m1_q   <= 1'b0;
      fetch_m2_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      host_rdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      rr_last_q    <= rr_last_d;
      cpu_rst_q    <= cpu_rst_d;
      a1_q         <= a1_d;
      a2_q         <= a2_d;
      lo_q         <= lo_d;
      fetch_m1_q   <= fetch_m1_d;
      fetch_m2_q   <= fetch_m2_d;
      host_ack_q   <= host_ack_d;
      host_rd_q    <= host_rd_d;
      host_rdata_q <= host_rdata;
    end
  end

endmodule

// File: tb/tb_mcs4_mem_arbiter.sv
// Directed bench for mcs4_mem_arbiter with a 1-cycle-latency sync RAM model.
module tb_mcs4_mem_arbiter;
  import mcs4_mem_arbiter_pkg::*;

`ifdef MCS4_ARB_WPROT_EN
  localparam logic WPROT = 1'b1;
`else
  localparam logic WPROT = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  cpu_dbus_out, cpu_dbus_in;
  logic        cpu_sync, cpu_rst;
  logic        ld_valid, ld_last, ld_ready;
  logic [7:0]  ld_data;
  logic        host_req, host_we, host_run, host_reload, host_ack;
  logic [11:0] host_addr, mem_addr;
  logic [7:0]  host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  logic [7:0]  mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  int n_chk = 0;
  int n_pass = 0;

  mcs4_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_dbus_out(cpu_dbus_out), .cpu_sync(cpu_sync),
    .cpu_dbus_in(cpu_dbus_in), .cpu_rst(cpu_rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_run(host_run), .host_reload(host_reload),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  logic [11:0] wrap_exp [4];

  initial begin
    wrap_exp = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000};
    rst_n = 1'b1; cpu_dbus_out = 4'h0; cpu_sync = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 12'h000; host_wdata = 8'h00;
    host_run = 1'b0; host_reload = 1'b0; pre_we = 1'b0; pre_addr = 12'h0; pre_data = 8'h0;
    #1 rst_n = 1'b0;
    preload(12'h234, 8'hA5);
    preload(12'h010, 8'h00);

    // Reset values, with requesters active to show they are masked.
    ld_valid = 1'b1; ld_data = 8'h99; host_req = 1'b1;
    settle();
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_dbus_in", cpu_dbus_in, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rdata", host_rdata, 0);
    host_req = 1'b0; ld_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Boot load of three bytes, last one with host_run set.
    ld_valid = 1'b1; ld_data = 8'h20; settle();
    chk("ld0_ready", ld_ready, 1);
    chk("ld0_addr", mem_addr, 12'h000);
    chk("ld0_we", mem_we, 1);
    chk("ld0_wdata", mem_wdata, 8'h20);
    step();
    ld_data = 8'h31; settle();
    chk("ld1_addr", mem_addr, 12'h001);
    step();
    ld_data = 8'hF0; ld_last = 1'b1; host_run = 1'b1; settle();
    chk("ld2_ready", ld_ready, 1);
    chk("ld2_addr", mem_addr, 12'h002);
    step();
    ld_valid = 1'b0; ld_last = 1'b0; settle();
    chk("boot_cpu_rst_p1", cpu_rst, 1);
    chk("boot_mem", {mem[0], mem[1], mem[2]}, 24'h2031F0);
    step(); settle();
    chk("boot_cpu_rst_p2", cpu_rst, 0);

    // Fetch of 0x234 with a host read of 0x002 arriving in A3.
    cpu_sync = 1'b1;
    step();
    cpu_sync = 1'b0; cpu_dbus_out = 4'h4; settle();
    chk("a1_dbus_in", cpu_dbus_in, 0);
    chk("a1_mem_en", mem_en, 0);
    step();
    cpu_dbus_out = 4'h3;
    step();
    cpu_dbus_out = 4'h2; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h002; settle();
    chk("a3_mem_en", mem_en, 1);
    chk("a3_mem_we", mem_we, 0);
    chk("a3_mem_addr", mem_addr, 12'h234);
    step();
    cpu_dbus_out = 4'h0; settle();
    chk("m1_dbus_in", cpu_dbus_in, 4'hA);
    chk("m1_host_addr", mem_addr, 12'h002);
    chk("m1_host_ack", host_ack, 0);
    step(); settle();
    chk("m2_dbus_in", cpu_dbus_in, 4'h5);
    chk("m2_host_ack", host_ack, 1);
    chk("m2_host_rdata", host_rdata, 8'hF0);
    step();

    // Host write in RUN, then drop host_run.
    host_we = 1'b1; host_addr = 12'h010; host_wdata = 8'h77; settle();
    chk("x1_dbus_in", cpu_dbus_in, 0);
    chk("run_wr_en", mem_en, 1);
    chk("run_wr_we", mem_we, {31'b0, !WPROT});
    chk("run_wr_addr", mem_addr, 12'h010);
    chk("run_rdata_hold", host_rdata, 8'hF0);
    step();
    host_req = 1'b0; host_run = 1'b0; settle();
    chk("run_wr_ack", host_ack, 1);
    chk("run_wr_rdata", host_rdata, 8'hF0);
    step(); settle();
    chk("run_wr_mem", mem[12'h010], WPROT ? 8'h00 : 8'h77);
    chk("halt_cpu_rst_lag", cpu_rst, 0);
    step(); settle();
    chk("halt_cpu_rst", cpu_rst, 1);
    step(); settle();
    chk("halt_phase_valid", dut.u_phase.phase_valid, 0);
    host_req = 1'b1; settle();
    chk("halt_wr_we", mem_we, 1);
    step();
    host_req = 1'b0; settle();
    chk("halt_wr_ack", host_ack, 1);
    step(); settle();
    chk("halt_wr_mem", mem[12'h010], 8'h77);
    host_reload = 1'b1;
    step();

    // Reload, stream to near the top of memory.
    host_reload = 1'b0; ld_valid = 1'b1; ld_data = 8'h11;
    for (int i = 0; i < 4093; i++) begin
      if (i == 0) begin
        settle();
        chk("reload_ptr", mem_addr, 12'h000);
        chk("reload_ready", ld_ready, 1);
        chk("reload_cpu_rst", cpu_rst, 1);
      end
      step();
    end

    // Host and loader contend; grants alternate and the pointer wraps.
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h005;
    for (int c = 0; c < 8; c++) begin
      settle();
      if ((c % 2) == 0) begin
        chk("ct_host_addr", mem_addr, 12'h005);
        chk("ct_host_ldrdy", ld_ready, 0);
      end else begin
        chk("ct_ack", host_ack, 1);
        chk("ct_rdata", host_rdata, 8'h11);
        chk("ct_ld_ready", ld_ready, 1);
        chk("ct_ld_addr", mem_addr, wrap_exp[c/2]);
      end
      step();
    end

    // Asynchronous reset in the middle of a load.
    host_req = 1'b0; ld_data = 8'h22; settle();
    chk("pre_arst_ready", ld_ready, 1);
    chk("pre_arst_addr", mem_addr, 12'h001);
    rst_n = 1'b0;
    #1;
    chk("arst_ld_ready", ld_ready, 0);
    chk("arst_mem_en", mem_en, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_host_rdata", host_rdata, 0);
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_dbus_in", cpu_dbus_in, 0);
    step();
    rst_n = 1'b1;

    // Reload while a byte is accepted: that byte lands at the old pointer.
    ld_data = 8'h33; settle();
    chk("sim_b0_addr", mem_addr, 12'h000);
    step();
    ld_data = 8'h44; host_reload = 1'b1; settle();
    chk("sim_b1_addr", mem_addr, 12'h001);
    step();
    host_reload = 1'b0; ld_data = 8'h55; settle();
    chk("sim_b2_addr", mem_addr, 12'h000);
    step();
    ld_valid = 1'b0; settle();
    chk("sim_mem", {mem[0], mem[1]}, 16'h5544);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
